// File: rtl/ddr2_cal_sequencer_if.sv
// Board-side bundle for the DDR2 calibration sequencer: EMIF status inputs, reset and LED status outputs.
// The master modport is the sequencer; the slave modport is the EMIF/board side.
interface ddr2_cal_sequencer_if;
    logic       pll_locked;
    logic       local_init_done;
    logic       local_cal_success;
    logic       local_cal_fail;
    logic       retry_req;
    logic       emif_soft_reset_n;
    logic       sys_reset_n;
    logic [2:0] state_code;
    logic [1:0] retry_count;
    logic       cal_failed;

    modport master (
        input  pll_locked, local_init_done, local_cal_success, local_cal_fail, retry_req,
        output emif_soft_reset_n, sys_reset_n, state_code, retry_count, cal_failed
    );

    modport slave (
        output pll_locked, local_init_done, local_cal_success, local_cal_fail, retry_req,
        input  emif_soft_reset_n, sys_reset_n, state_code, retry_count, cal_failed
    );
endinterface

// File: rtl/ddr2_cal_sequencer.sv
// DDR2 EMIF bring-up sequencer: soft-reset pulse, PLL/calibration wait, settle, retry and sticky fail.
// Define CAL_SEQ_LOCK_FILTER_EN to filter short loss-of-lock glitches in SETTLE and RUN.
module ddr2_cal_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES     = 50000000,
    parameter int unsigned RST_PULSE_CYCLES   = 1024,
    parameter int unsigned SETTLE_CYCLES      = 256,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned LOCK_FILTER_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ddr2_cal_sequencer_if.master bus
);
    // One counter width covers every programmable interval, including the lock filter.
    localparam int unsigned MAX_A   = (TIMEOUT_CYCLES > RST_PULSE_CYCLES) ? TIMEOUT_CYCLES : RST_PULSE_CYCLES;
    localparam int unsigned MAX_B   = (SETTLE_CYCLES > LOCK_FILTER_CYCLES) ? SETTLE_CYCLES : LOCK_FILTER_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    localparam logic [TW-1:0] ONE          = TW'(1);
    localparam logic [TW-1:0] RST_LAST     = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD     = 3'd1,
        S_WAIT_PLL = 3'd2,
        S_WAIT_CAL = 3'd3,
        S_SETTLE   = 3'd4,
        S_RUN      = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    retry_q, retry_d;
    logic          emif_rst_n_q, emif_rst_n_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          cal_failed_q, cal_failed_d;
    logic [3:0]    sync1_q, sync2_q;
    logic          lock_s, init_s, succ_s, fail_s;
    logic          lock_lost;
    logic          attempt_fail;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.local_cal_fail, bus.local_cal_success, bus.local_init_done, bus.pll_locked};
            sync2_q <= sync1_q;
        end
    end

    assign {fail_s, succ_s, init_s, lock_s} = sync2_q;

`ifdef CAL_SEQ_LOCK_FILTER_EN
    localparam logic [TW-1:0] LF_LAST = TW'(LOCK_FILTER_CYCLES - 1);

    logic [TW-1:0] filt_q, filt_d;

    // filt_q counts earlier consecutive low cycles; the LOCK_FILTER_CYCLES-th one is a real loss.
    always_comb begin
        filt_d = '0;
        if ((state_q == S_SETTLE || state_q == S_RUN) && !lock_s) begin
            filt_d = (filt_q == LF_LAST) ? filt_q : filt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign lock_lost = !lock_s && (filt_q == LF_LAST);
`else
    assign lock_lost = !lock_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_HOLD;
            timer_q      <= '0;
            retry_q      <= '0;
            emif_rst_n_q <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            cal_failed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            emif_rst_n_q <= emif_rst_n_d;
            sys_rst_n_q  <= sys_rst_n_d;
            cal_failed_q <= cal_failed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        attempt_fail = 1'b0;
        timer_d      = (timer_q == '1) ? timer_q : timer_q + ONE;

        case (state_q)
            S_HOLD: begin
                if (timer_q == RST_LAST) begin
                    state_d = S_WAIT_PLL;
                end
            end
            S_WAIT_PLL: begin
                if (lock_s) begin
                    state_d = S_WAIT_CAL;
                end else if (timer_q == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            S_WAIT_CAL: begin
                if (fail_s || !lock_s) begin
                    attempt_fail = 1'b1;
                end else if (init_s && succ_s) begin
                    state_d = S_SETTLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            S_SETTLE: begin
                if (lock_lost || !init_s || !succ_s || fail_s) begin
                    attempt_fail = 1'b1;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (lock_lost || fail_s || !succ_s) begin
                    attempt_fail = 1'b1;
                end
            end
            S_FAIL: begin
                if (bus.retry_req) begin
                    state_d = S_HOLD;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        // A failed attempt either retries from HOLD or, once the budget is spent, parks in FAIL.
        if (attempt_fail) begin
            if (retry_q == RETRY_LIMIT) begin
                state_d = S_FAIL;
            end else begin
                state_d = S_HOLD;
                retry_d = retry_q + 2'd1;
            end
        end

        if (state_d == S_RUN && state_q != S_RUN) begin
            retry_d = '0;
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_comb begin
        emif_rst_n_d = 1'b0;
        sys_rst_n_d  = 1'b0;
        cal_failed_d = 1'b0;
        case (state_d)
            S_WAIT_PLL, S_WAIT_CAL, S_SETTLE: begin
                emif_rst_n_d = 1'b1;
            end
            S_RUN: begin
                emif_rst_n_d = 1'b1;
                sys_rst_n_d  = 1'b1;
            end
            S_FAIL: begin
                cal_failed_d = 1'b1;
            end
            default: begin
                emif_rst_n_d = 1'b0;
            end
        endcase
    end

    assign bus.emif_soft_reset_n = emif_rst_n_q;
    assign bus.sys_reset_n       = sys_rst_n_q;
    assign bus.state_code        = state_q;
    assign bus.retry_count       = retry_q;
    assign bus.cal_failed        = cal_failed_q;
endmodule

// File: tb/tb_ddr2_cal_sequencer.sv
// Self-checking bench for ddr2_cal_sequencer: cycle model of the sequencing rules plus directed scenarios.
module tb_ddr2_cal_sequencer;
    localparam int TO = 100;
    localparam int RP = 8;
    localparam int SC = 4;
    localparam int MR = 2;
`ifdef CAL_SEQ_LOCK_FILTER_EN
    localparam int LFN = 16;
`else
    localparam int LFN = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   cmp_en = 1'b0;

    ddr2_cal_sequencer_if bus_if ();

    ddr2_cal_sequencer #(
        .TIMEOUT_CYCLES    (TO),
        .RST_PULSE_CYCLES  (RP),
        .SETTLE_CYCLES     (SC),
        .MAX_RETRIES       (MR),
        .LOCK_FILTER_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: states by their status code, sync inputs as a 2-deep delay line.
    int       m_state, m_cnt, m_rc, m_low;
    bit [3:0] m_s1, m_s2;

    always @(posedge clk or negedge reset_n) begin : model
        int ns, rc, low;
        bit fa, lk, id, cs, cf, lost;
        if (!reset_n) begin
            m_state <= 1;
            m_cnt   <= 0;
            m_rc    <= 0;
            m_low   <= 0;
            m_s1    <= '0;
            m_s2    <= '0;
        end else begin
            {cf, cs, id, lk} = m_s2;
            ns   = m_state;
            rc   = m_rc;
            fa   = 1'b0;
            low  = ((m_state == 4 || m_state == 5) && !lk) ? m_low + 1 : 0;
            lost = !lk && (low >= LFN);
            case (m_state)
                1: if (m_cnt == RP - 1) ns = 2;
                2: if (lk) ns = 3; else if (m_cnt == TO - 1) fa = 1'b1;
                3: if (cf || !lk) fa = 1'b1; else if (id && cs) ns = 4; else if (m_cnt == TO - 1) fa = 1'b1;
                4: if (lost || !id || !cs || cf) fa = 1'b1; else if (m_cnt == SC - 1) ns = 5;
                5: if (lost || cf || !cs) fa = 1'b1;
                6: if (bus_if.retry_req) begin ns = 1; rc = 0; end
                default: ns = 1;
            endcase
            if (fa) begin
                if (rc == MR) ns = 6;
                else begin ns = 1; rc = rc + 1; end
            end
            if (ns == 5 && m_state != 5) rc = 0;
            m_cnt   <= (ns != m_state) ? 0 : m_cnt + 1;
            m_state <= ns;
            m_rc    <= rc;
            m_low   <= low;
            m_s2    <= m_s1;
            m_s1    <= {bus_if.local_cal_fail, bus_if.local_cal_success, bus_if.local_init_done, bus_if.pll_locked};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_state_code", 32'(bus_if.state_code), 32'(m_state));
            check("cmp_emif_soft_reset_n", 32'(bus_if.emif_soft_reset_n), 32'(m_state >= 2 && m_state <= 5));
            check("cmp_sys_reset_n", 32'(bus_if.sys_reset_n), 32'(m_state == 5));
            check("cmp_retry_count", 32'(bus_if.retry_count), 32'(m_rc));
            check("cmp_cal_failed", 32'(bus_if.cal_failed), 32'(m_state == 6));
        end
    end

    task automatic wait_state(input logic [2:0] code, input int budget, input string name);
        int n = 0;
        while (bus_if.state_code !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus_if.state_code), 32'(code));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic count_emif_low(input string name);
        int n = 0;
        while (!bus_if.emif_soft_reset_n && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(RP));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(bus_if.state_code), 32'd1);
        check({tag, "_emif"}, 32'(bus_if.emif_soft_reset_n), 32'd0);
        check({tag, "_sys"}, 32'(bus_if.sys_reset_n), 32'd0);
        check({tag, "_rc"}, 32'(bus_if.retry_count), 32'd0);
        check({tag, "_calf"}, 32'(bus_if.cal_failed), 32'd0);
    endtask

    initial begin
        int n;
        reset_n                  = 1'b0;
        bus_if.pll_locked        = 1'b1;
        bus_if.local_init_done   = 1'b0;
        bus_if.local_cal_success = 1'b0;
        bus_if.local_cal_fail    = 1'b0;
        bus_if.retry_req         = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        // 1: nominal bring-up
        count_emif_low("t1_emif_low_cycles");
        repeat (20) @(negedge clk);
        bus_if.local_init_done   = 1'b1;
        bus_if.local_cal_success = 1'b1;
        n = 0;
        while (!bus_if.sys_reset_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t1_cal_to_sys_cycles", 32'(n), 32'd7);
        check("t1_state_run", 32'(bus_if.state_code), 32'd5);
        check("t1_rc", 32'(bus_if.retry_count), 32'd0);

        // 2: calibration fail on first attempt, success on second
        bus_if.local_init_done   = 1'b0;
        bus_if.local_cal_success = 1'b0;
        apply_reset();
        wait_state(3'd3, 30, "t2_reach_wait_cal");
        bus_if.local_cal_fail = 1'b1;
        repeat (10) @(negedge clk);
        bus_if.local_cal_fail = 1'b0;
        wait_state(3'd3, 30, "t2_second_wait_cal");
        check("t2_rc_in_attempt", 32'(bus_if.retry_count), 32'd1);
        bus_if.local_init_done   = 1'b1;
        bus_if.local_cal_success = 1'b1;
        wait_state(3'd5, 30, "t2_reach_run");
        check("t2_rc_run", 32'(bus_if.retry_count), 32'd0);

        // retry_req is ignored outside FAIL
        bus_if.retry_req = 1'b1;
        @(negedge clk);
        bus_if.retry_req = 1'b0;
        repeat (3) @(negedge clk);
        check("retry_ignored_in_run", 32'(bus_if.state_code), 32'd5);

        // 4: loss of lock in RUN
`ifdef CAL_SEQ_LOCK_FILTER_EN
        bus_if.pll_locked = 1'b0;
        @(negedge clk);
        bus_if.pll_locked = 1'b1;
        repeat (10) @(negedge clk);
        check("t4_short_drop_ignored", 32'(bus_if.sys_reset_n), 32'd1);
`endif
        bus_if.pll_locked = 1'b0;
        n = 0;
        while (bus_if.sys_reset_n && n < 40) begin
            @(negedge clk);
            n++;
            if (n == ((LFN > 1) ? 20 : 1)) bus_if.pll_locked = 1'b1;
        end
        check("t4_drop_to_sys_low", 32'(n), (LFN > 1) ? 32'd18 : 32'd3);
        check("t4_state_hold", 32'(bus_if.state_code), 32'd1);
        check("t4_rc", 32'(bus_if.retry_count), 32'd1);
        bus_if.pll_locked = 1'b1;

        // 3: PLL never locks -> three timed-out attempts -> FAIL
        bus_if.pll_locked        = 1'b0;
        bus_if.local_init_done   = 1'b0;
        bus_if.local_cal_success = 1'b0;
        apply_reset();
        n = 0;
        while (bus_if.state_code !== 3'd6 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t3_cycles_to_fail", 32'(n), 32'd324);
        check("t3_calf", 32'(bus_if.cal_failed), 32'd1);
        check("t3_emif", 32'(bus_if.emif_soft_reset_n), 32'd0);
        check("t3_sys", 32'(bus_if.sys_reset_n), 32'd0);
        check("t3_rc", 32'(bus_if.retry_count), 32'd2);
        repeat (5) @(negedge clk);
        check("t3_fail_sticky", 32'(bus_if.state_code), 32'd6);
        bus_if.retry_req = 1'b1;
        @(negedge clk);
        bus_if.retry_req = 1'b0;
        check("t3_retry_state", 32'(bus_if.state_code), 32'd1);
        check("t3_retry_rc", 32'(bus_if.retry_count), 32'd0);
        check("t3_retry_calf", 32'(bus_if.cal_failed), 32'd0);

        // 5: simultaneous cal_fail and cal_success in WAIT_CAL
        bus_if.pll_locked = 1'b1;
        wait_state(3'd3, 40, "t5_reach_wait_cal");
        bus_if.local_cal_fail    = 1'b1;
        bus_if.local_cal_success = 1'b1;
        bus_if.local_init_done   = 1'b1;
        @(negedge clk);
        bus_if.local_cal_fail    = 1'b0;
        bus_if.local_cal_success = 1'b0;
        bus_if.local_init_done   = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_state_hold", 32'(bus_if.state_code), 32'd1);
        check("t5_rc", 32'(bus_if.retry_count), 32'd1);

        // 6: async reset during SETTLE, then restart
        wait_state(3'd3, 40, "t6_reach_wait_cal");
        bus_if.local_cal_success = 1'b1;
        bus_if.local_init_done   = 1'b1;
        wait_state(3'd4, 10, "t6_reach_settle");
        #2 reset_n = 1'b0;
        #1 check_reset_values("t6_async");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        count_emif_low("t6_emif_low_cycles");
        wait_state(3'd5, 60, "t6_reach_run");
        check("t6_rc", 32'(bus_if.retry_count), 32'd0);
        check("t6_sys", 32'(bus_if.sys_reset_n), 32'd1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
